// File: rtl/bp_resolve_queue.sv
// In-order queue of branch predictions, popped at resolve to drive the PHT update and GHR recovery.
// Optional resolve/mispredict statistics counters enabled by defining BP_RESOLVE_STATS_EN.
module bp_resolve_queue #(
  parameter int PHT_DEPTH   = 7,
  parameter int GHR_WIDTH   = 4,
  parameter int QDEPTH_LOG2 = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_valid,
  input  logic [PHT_DEPTH-1:0]   push_index,
  input  logic                   push_pred,
  input  logic [GHR_WIDTH-1:0]   push_ghr_alt,
  output logic                   full,
  output logic [QDEPTH_LOG2:0]   count,
  input  logic                   resolve_valid,
  input  logic                   resolve_taken,
  input  logic                   flush,
  output logic                   upd_valid,
  output logic [PHT_DEPTH-1:0]   upd_index,
  output logic                   upd_taken,
  output logic                   mispredict,
  output logic [GHR_WIDTH-1:0]   recover_ghr,
  output logic                   underflow,
  output logic [15:0]            stat_total,
  output logic [15:0]            stat_miss
);

  localparam int DEPTH = 1 << QDEPTH_LOG2;
  localparam logic [QDEPTH_LOG2:0] DEPTH_C = (QDEPTH_LOG2 + 1)'(DEPTH);

  typedef struct packed {
    logic [PHT_DEPTH-1:0] index;
    logic                 pred;
    logic [GHR_WIDTH-1:0] ghr_alt;
  } entry_t;

  entry_t                 mem [DEPTH];
  logic [QDEPTH_LOG2-1:0] head;
  logic [QDEPTH_LOG2-1:0] tail;
  logic [QDEPTH_LOG2:0]   cnt;
  entry_t                 head_ent;
  logic                   pop;
  logic                   miss;
  logic                   push_ok;

  assign head_ent = mem[head];
  assign pop      = resolve_valid && (cnt != '0);
  assign miss     = pop && (head_ent.pred != resolve_taken);
  // A push at full still fits when the head leaves on the same edge.
  assign push_ok  = push_valid && !flush && !miss && ((cnt != DEPTH_C) || pop);

  assign count = cnt;
  assign full  = (cnt == DEPTH_C);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush || miss) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (pop)     head <= head + 1'b1;
      if (push_ok) tail <= tail + 1'b1;
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[tail] <= '{index: push_index, pred: push_pred, ghr_alt: push_ghr_alt};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd_valid   <= 1'b0;
      upd_index   <= '0;
      upd_taken   <= 1'b0;
      mispredict  <= 1'b0;
      recover_ghr <= '0;
      underflow   <= 1'b0;
    end else begin
      upd_valid  <= pop;
      mispredict <= miss;
      if (pop) begin
        upd_index   <= head_ent.index;
        upd_taken   <= resolve_taken;
        recover_ghr <= head_ent.ghr_alt;
      end
      if (resolve_valid && (cnt == '0)) underflow <= 1'b1;
    end
  end

`ifdef BP_RESOLVE_STATS_EN
  logic [15:0] total_q;
  logic [15:0] miss_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total_q <= '0;
      miss_q  <= '0;
    end else begin
      if (pop && (total_q != 16'hFFFF)) total_q <= total_q + 16'd1;
      if (miss && (miss_q != 16'hFFFF)) miss_q <= miss_q + 16'd1;
    end
  end

  assign stat_total = total_q;
  assign stat_miss  = miss_q;
`else
  assign stat_total = '0;
  assign stat_miss  = '0;
`endif

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed-vector bench for bp_resolve_queue; stats expectations follow BP_RESOLVE_STATS_EN.
module tb_bp_resolve_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        push_valid = 1'b0;
  logic [6:0]  push_index = '0;
  logic        push_pred = 1'b0;
  logic [3:0]  push_ghr_alt = '0;
  logic        full;
  logic [2:0]  count;
  logic        resolve_valid = 1'b0;
  logic        resolve_taken = 1'b0;
  logic        flush = 1'b0;
  logic        upd_valid;
  logic [6:0]  upd_index;
  logic        upd_taken;
  logic        mispredict;
  logic [3:0]  recover_ghr;
  logic        underflow;
  logic [15:0] stat_total;
  logic [15:0] stat_miss;

  int errors = 0;
  int checks = 0;

  bp_resolve_queue dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_index(push_index), .push_pred(push_pred),
    .push_ghr_alt(push_ghr_alt), .full(full), .count(count),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .flush(flush),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .mispredict(mispredict), .recover_ghr(recover_ghr), .underflow(underflow),
    .stat_total(stat_total), .stat_miss(stat_miss)
  );

  always #5 clk = ~clk;

  // Drives one cycle of inputs, returns 1ns after the edge that consumed them.
  task automatic cyc(input logic pv, input logic [6:0] pi, input logic pp, input logic [3:0] pg,
                     input logic rv, input logic rt, input logic fl);
    push_valid = pv; push_index = pi; push_pred = pp; push_ghr_alt = pg;
    resolve_valid = rv; resolve_taken = rt; flush = fl;
    @(posedge clk); #1;
    push_valid = 1'b0; resolve_valid = 1'b0; resolve_taken = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    #4 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if ({upd_valid, mispredict, underflow, upd_taken} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {upd_valid, mispredict, underflow, upd_taken}); end
    checks++; if ({upd_index, recover_ghr} !== 11'h0) begin
      errors++; $display("FAIL reset_idx_ghr got=%h exp=000", {upd_index, recover_ghr}); end
    checks++; if ({stat_total, stat_miss} !== 32'h0) begin
      errors++; $display("FAIL reset_stats got=%h exp=0", {stat_total, stat_miss}); end
    #8 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_and_drain();
    logic [6:0] idx [4];
    logic       prd [4];
    idx[0] = 7'h05; idx[1] = 7'h11; idx[2] = 7'h22; idx[3] = 7'h7F;
    prd[0] = 1'b1;  prd[1] = 1'b0;  prd[2] = 1'b1;  prd[3] = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b1, idx[i], prd[i], 4'(i + 1), 1'b0, 1'b0, 1'b0);
    checks++; if (full !== 1'b1 || count !== 3'd4) begin
      errors++; $display("FAIL fill_full got full=%b count=%0d exp full=1 count=4", full, count); end
    cyc(1'b1, 7'h33, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL push_at_full got=%0d exp=4", count); end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 7'h0, 1'b0, 4'h0, 1'b1, prd[i], 1'b0);
      checks++; if (upd_valid !== 1'b1 || upd_index !== idx[i] || upd_taken !== prd[i] || mispredict !== 1'b0) begin
        errors++; $display("FAIL drain_%0d got v=%b idx=%h t=%b m=%b exp v=1 idx=%h t=%b m=0",
                           i, upd_valid, upd_index, upd_taken, mispredict, idx[i], prd[i]); end
    end
    checks++; if (recover_ghr !== 4'h4) begin errors++; $display("FAIL drain_ghr got=%h exp=4", recover_ghr); end
    cyc(1'b0, 7'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (upd_valid !== 1'b0 || upd_index !== 7'h7F || count !== 3'd0) begin
      errors++; $display("FAIL drain_idle got v=%b idx=%h cnt=%0d exp v=0 idx=7f cnt=0", upd_valid, upd_index, count); end
  endtask

  task automatic test_mispredict();
    cyc(1'b1, 7'h10, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 7'h11, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 7'h12, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 7'h13, 1'b1, 4'hD, 1'b1, 1'b0, 1'b0);
    checks++; if (mispredict !== 1'b1 || recover_ghr !== 4'hA || upd_index !== 7'h10 || upd_taken !== 1'b0) begin
      errors++; $display("FAIL miss_out got m=%b ghr=%h idx=%h t=%b exp m=1 ghr=a idx=10 t=0",
                         mispredict, recover_ghr, upd_index, upd_taken); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL miss_squash got=%0d exp=0", count); end
    cyc(1'b0, 7'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (mispredict !== 1'b0 || upd_valid !== 1'b0) begin
      errors++; $display("FAIL miss_pulse got m=%b v=%b exp 0 0", mispredict, upd_valid); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_idx;
    for (int i = 0; i < 4; i++) cyc(1'b1, 7'(8'h20 + i), 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 7'h24, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    checks++; if (count !== 3'd4 || full !== 1'b1 || upd_index !== 7'h20 || mispredict !== 1'b0) begin
      errors++; $display("FAIL b2b_full got cnt=%0d full=%b idx=%h m=%b exp 4 1 20 0",
                         count, full, upd_index, mispredict); end
    for (int i = 1; i <= 4; i++) begin
      exp_idx = 7'(8'h20 + i);
      cyc(1'b0, 7'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      checks++; if (upd_valid !== 1'b1 || upd_index !== exp_idx) begin
        errors++; $display("FAIL b2b_order_%0d got v=%b idx=%h exp v=1 idx=%h", i, upd_valid, upd_index, exp_idx); end
    end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_empty got=%0d exp=0", count); end
  endtask

  task automatic test_flush();
    cyc(1'b1, 7'h30, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 7'h31, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 7'h32, 1'b0, 4'h7, 1'b1, 1'b1, 1'b1);
    checks++; if (upd_valid !== 1'b1 || upd_index !== 7'h30 || mispredict !== 1'b0 || recover_ghr !== 4'h5) begin
      errors++; $display("FAIL flush_resolve got v=%b idx=%h m=%b ghr=%h exp 1 30 0 5",
                         upd_valid, upd_index, mispredict, recover_ghr); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_clear got=%0d exp=0", count); end
  endtask

  task automatic test_underflow();
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_pre got=%b exp=0", underflow); end
    cyc(1'b0, 7'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    checks++; if (upd_valid !== 1'b0 || underflow !== 1'b1) begin
      errors++; $display("FAIL underflow_set got v=%b uf=%b exp v=0 uf=1", upd_valid, underflow); end
    for (int i = 0; i < 3; i++) cyc(1'b0, 7'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (underflow !== 1'b1 || count !== 3'd0) begin
      errors++; $display("FAIL underflow_sticky got uf=%b cnt=%0d exp uf=1 cnt=0", underflow, count); end
    do_reset();
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_reset got=%b exp=0", underflow); end
  endtask

  task automatic test_stats_and_async_reset();
    logic [15:0] exp_total;
    logic [15:0] exp_miss;
`ifdef BP_RESOLVE_STATS_EN
    exp_total = 16'd3; exp_miss = 16'd1;
`else
    exp_total = 16'd0; exp_miss = 16'd0;
`endif
    for (int i = 0; i < 3; i++) cyc(1'b1, 7'(8'h40 + i), 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 7'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 7'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 7'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    checks++; if (mispredict !== 1'b1 || upd_index !== 7'h42) begin
      errors++; $display("FAIL stats_miss_pulse got m=%b idx=%h exp m=1 idx=42", mispredict, upd_index); end
    checks++; if (stat_total !== exp_total || stat_miss !== exp_miss) begin
      errors++; $display("FAIL stats_counts got total=%0d miss=%0d exp total=%0d miss=%0d",
                         stat_total, stat_miss, exp_total, exp_miss); end
    cyc(1'b0, 7'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 7'(8'h50 + i), 1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 7'h54, 1'b1, 4'h9, 1'b1, 1'b1, 1'b0);
    checks++; if (count !== 3'd4 || upd_valid !== 1'b1 || underflow !== 1'b1) begin
      errors++; $display("FAIL pre_reset got cnt=%0d v=%b uf=%b exp 4 1 1", count, upd_valid, underflow); end
    #1 rst = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || full !== 1'b0) begin
      errors++; $display("FAIL async_reset_count got cnt=%0d full=%b exp 0 0", count, full); end
    checks++; if ({upd_valid, mispredict, underflow, upd_taken, upd_index, recover_ghr} !== 15'h0) begin
      errors++; $display("FAIL async_reset_outs got=%h exp=0",
                         {upd_valid, mispredict, underflow, upd_taken, upd_index, recover_ghr}); end
    checks++; if ({stat_total, stat_miss} !== 32'h0) begin
      errors++; $display("FAIL async_reset_stats got=%h exp=0", {stat_total, stat_miss}); end
    #6 rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill_and_drain();
    test_mispredict();
    test_back_to_back();
    test_flush();
    test_underflow();
    test_stats_and_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
